// File: rtl/pulse_len_tx.sv
// Pulse-length serial transmitter: each data bit is a space pulse (short = 1, long = 0) followed by a mark gap, LSB first.
// Optional even-parity ninth bit when PULSE_TX_PARITY_EN is defined.
module pulse_len_tx #(
  parameter int unsigned ONE_LEN  = 4,
  parameter int unsigned ZERO_LEN = 13,
  parameter int unsigned GAP_LEN  = 20
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] data,
  input  logic       start,
  output logic       ready,
  output logic       txd,
  output logic       done
);

  localparam logic [7:0] ONE_L  = 8'(ONE_LEN);
  localparam logic [7:0] ZERO_L = 8'(ZERO_LEN);
  localparam logic [7:0] GAP_L  = 8'(GAP_LEN);

`ifdef PULSE_TX_PARITY_EN
  localparam logic [3:0] LAST_IDX = 4'd8;
  typedef enum logic [1:0] {IDLE, SPACE, GAP, PAR} state_e;
`else
  localparam logic [3:0] LAST_IDX = 4'd7;
  typedef enum logic [1:0] {IDLE, SPACE, GAP} state_e;
`endif

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [6:0] shift_q, shift_d;
  logic [3:0] bit_idx_q, bit_idx_d;
  logic       txd_q, txd_d;
  logic       last_gap;
  logic       accept;
`ifdef PULSE_TX_PARITY_EN
  logic       par_q, par_d;
`endif

  // The final gap cycle already reports ready so a waiting start chains frames with no idle mark.
  assign last_gap = (state_q == GAP) && (cnt_q == 8'd1) && (bit_idx_q == LAST_IDX);
  assign ready    = (state_q == IDLE) || last_gap;
  assign done     = last_gap;
  assign accept   = start && ready;
  assign txd      = txd_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    txd_d     = txd_q;
`ifdef PULSE_TX_PARITY_EN
    par_d     = par_q;
`endif

    case (state_q)
      IDLE: begin
        txd_d = 1'b1;
      end
      SPACE: begin
        if (cnt_q == 8'd1) begin
          state_d = GAP;
          cnt_d   = GAP_L;
          txd_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
`ifdef PULSE_TX_PARITY_EN
      PAR: begin
        if (cnt_q == 8'd1) begin
          state_d = GAP;
          cnt_d   = GAP_L;
          txd_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
`endif
      GAP: begin
        if (cnt_q != 8'd1) begin
          cnt_d = cnt_q - 8'd1;
        end else if (bit_idx_q == LAST_IDX) begin
          state_d = IDLE;
          txd_d   = 1'b1;
`ifdef PULSE_TX_PARITY_EN
        end else if (bit_idx_q == 4'd7) begin
          state_d   = PAR;
          bit_idx_d = 4'd8;
          cnt_d     = par_q ? ONE_L : ZERO_L;
          txd_d     = 1'b0;
`endif
        end else begin
          state_d   = SPACE;
          bit_idx_d = bit_idx_q + 4'd1;
          cnt_d     = shift_q[0] ? ONE_L : ZERO_L;
          shift_d   = {1'b0, shift_q[6:1]};
          txd_d     = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        txd_d   = 1'b1;
      end
    endcase

    // Bit 0 goes out straight from the input; the shifter holds bits 7..1.
    if (accept) begin
      state_d   = SPACE;
      shift_d   = data[7:1];
      bit_idx_d = 4'd0;
      cnt_d     = data[0] ? ONE_L : ZERO_L;
      txd_d     = 1'b0;
`ifdef PULSE_TX_PARITY_EN
      par_d     = ^data;
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      shift_q   <= 7'd0;
      bit_idx_q <= 4'd0;
      txd_q     <= 1'b1;
`ifdef PULSE_TX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      txd_q     <= txd_d;
`ifdef PULSE_TX_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

endmodule
